// File: rtl/register_scoreboard.sv
// register_scoreboard
//   Producer-side hazard tracker for an 8-entry register file. A small
//   saturating counter per register counts writes that have been issued but
//   not yet retired at WB. Issue is held while a used source has a pending
//   write that same-cycle WB forwarding cannot supply, or while the
//   destination counter is full. A drain handshake lets flush/halt logic wait
//   until every counter has returned to zero.
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   issue_valid                 instruction presented at issue
//   issue_we / issue_dest       instruction writes issue_dest
//   issue_use_a / issue_src_a   instruction reads source A
//   issue_use_b / issue_src_b   instruction reads source B
//   issue_ready                 combinational; accept when issue_valid && issue_ready
//   WriteEnable_WB              WB retires a write this cycle
//   WriteRegAddr_WB             register retired by WB
//   drain_req                   level request: block issue until nothing pending
//   drained                     registered: drain complete, all counters zero
//   busy_mask                   registered: bit r set while register r has pending writes
//   stall_cycles                saturating count of cycles with issue_valid && !issue_ready
//   wb_underflow                sticky: WB retired a register whose counter was zero
module register_scoreboard #(
    parameter int NUM_REGS    = 8,
    parameter int ADDR_W      = 3,
    parameter int CNT_W       = 2,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic                   issue_we,
    input  logic [ADDR_W-1:0]      issue_dest,
    input  logic                   issue_use_a,
    input  logic [ADDR_W-1:0]      issue_src_a,
    input  logic                   issue_use_b,
    input  logic [ADDR_W-1:0]      issue_src_b,
    output logic                   issue_ready,
    input  logic                   WriteEnable_WB,
    input  logic [ADDR_W-1:0]      WriteRegAddr_WB,
    input  logic                   drain_req,
    output logic                   drained,
    output logic [NUM_REGS-1:0]    busy_mask,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   wb_underflow
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAINING = 2'd1,
        DRAINED  = 2'd2
    } stateType;

    localparam logic [CNT_W-1:0]       CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]       CNT_MAX   = '1;
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

    stateType                          stateReg, stateNext;
    logic [NUM_REGS-1:0][CNT_W-1:0]    pendReg;
    logic [NUM_REGS-1:0][CNT_W-1:0]    pendNext;
    logic [NUM_REGS-1:0]               busyNext;
    logic [NUM_REGS-1:0]               busyMaskReg;
    logic                              drainedReg;
    logic [STALL_CNT_W-1:0]            stallReg;
    logic                              underflowReg;

    logic hazardA, hazardB, hazardDest;
    logic wbHitA, wbHitB;
    logic accepted;
    logic underflowHit;
    logic allZeroNext;

    // A count of one is safe only when WB retires that very write this
    // cycle, because the forwarding path delivers the WB data to EX.
    function automatic logic srcHazard(input logic used,
                                       input logic [CNT_W-1:0] cnt,
                                       input logic wbHit);
        return used && ((cnt > CNT_ONE) || ((cnt == CNT_ONE) && !wbHit));
    endfunction

    assign wbHitA     = WriteEnable_WB && (WriteRegAddr_WB == issue_src_a);
    assign wbHitB     = WriteEnable_WB && (WriteRegAddr_WB == issue_src_b);
    assign hazardA    = srcHazard(issue_use_a, pendReg[issue_src_a], wbHitA);
    assign hazardB    = srcHazard(issue_use_b, pendReg[issue_src_b], wbHitB);
    // No WB bypass on the destination: a full counter always blocks.
    assign hazardDest = issue_we && (pendReg[issue_dest] == CNT_MAX);

    assign issue_ready  = (stateReg == IDLE) && !hazardA && !hazardB && !hazardDest;
    assign accepted     = issue_valid && issue_ready;
    assign underflowHit = WriteEnable_WB && (pendReg[WriteRegAddr_WB] == CNT_ZERO);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : genPend
            logic incHit, decHit;
            assign incHit = accepted && issue_we && (issue_dest == ADDR_W'(gi));
            assign decHit = WriteEnable_WB && (WriteRegAddr_WB == ADDR_W'(gi))
                            && (pendReg[gi] != CNT_ZERO);
            // Simultaneous issue and retire of the same register cancel out.
            assign pendNext[gi] = (incHit && !decHit) ? pendReg[gi] + CNT_ONE :
                                  (decHit && !incHit) ? pendReg[gi] - CNT_ONE :
                                                        pendReg[gi];
            assign busyNext[gi] = (pendNext[gi] != CNT_ZERO);
        end
    endgenerate

    assign allZeroNext = (busyNext == '0);

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:     if (drain_req) stateNext = DRAINING;
            DRAINING: begin
                if (!drain_req)       stateNext = IDLE;
                else if (allZeroNext) stateNext = DRAINED;
            end
            DRAINED:  if (!drain_req) stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= IDLE;
            pendReg      <= '0;
            busyMaskReg  <= '0;
            drainedReg   <= 1'b0;
            stallReg     <= '0;
            underflowReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            pendReg     <= pendNext;
            busyMaskReg <= busyNext;
            drainedReg  <= (stateNext == DRAINED);
            if (issue_valid && !issue_ready && (stallReg != STALL_MAX)) begin
                stallReg <= stallReg + STALL_ONE;
            end
            if (underflowHit) begin
                underflowReg <= 1'b1;
            end
        end
    end

    assign drained      = drainedReg;
    assign busy_mask    = busyMaskReg;
    assign stall_cycles = stallReg;
    assign wb_underflow = underflowReg;

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard. Expected values are pushed into a
// scoreboard queue as each stimulus step is driven and popped when the DUT
// output for that step is sampled (1-2 time units after the rising edge).
module tb_register_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid, issue_we, issue_use_a, issue_use_b;
    logic [2:0] issue_dest, issue_src_a, issue_src_b;
    logic       issue_ready;
    logic       WriteEnable_WB;
    logic [2:0] WriteRegAddr_WB;
    logic       drain_req;
    logic       drained;
    logic [7:0] busy_mask;
    logic [7:0] stall_cycles;
    logic       wb_underflow;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } expType;

    expType sbq[$];
    int     checks   = 0;
    int     failures = 0;

    register_scoreboard dut (
        .clk             (clk),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_we        (issue_we),
        .issue_dest      (issue_dest),
        .issue_use_a     (issue_use_a),
        .issue_src_a     (issue_src_a),
        .issue_use_b     (issue_use_b),
        .issue_src_b     (issue_src_b),
        .issue_ready     (issue_ready),
        .WriteEnable_WB  (WriteEnable_WB),
        .WriteRegAddr_WB (WriteRegAddr_WB),
        .drain_req       (drain_req),
        .drained         (drained),
        .busy_mask       (busy_mask),
        .stall_cycles    (stall_cycles),
        .wb_underflow    (wb_underflow)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        expType e;
        e.tag = tag;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic popCheck(input logic [31:0] obs);
        expType e;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
            $display("check %-22s observed=%0h expected=%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic idle();
        issue_valid     = 1'b0;
        issue_we        = 1'b0;
        issue_dest      = 3'd0;
        issue_use_a     = 1'b0;
        issue_src_a     = 3'd0;
        issue_use_b     = 1'b0;
        issue_src_b     = 3'd0;
        WriteEnable_WB  = 1'b0;
        WriteRegAddr_WB = 3'd0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issueWrite(input logic [2:0] d);
        idle();
        issue_valid = 1'b1;
        issue_we    = 1'b1;
        issue_dest  = d;
    endtask

    task automatic issueRead(input logic [2:0] s);
        idle();
        issue_valid = 1'b1;
        issue_use_a = 1'b1;
        issue_src_a = s;
    endtask

    task automatic wbOnly(input logic [2:0] a);
        idle();
        WriteEnable_WB  = 1'b1;
        WriteRegAddr_WB = a;
    endtask

    initial begin
        idle();
        drain_req = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        push("rst_ready", 1); push("rst_drained", 0); push("rst_busy", 0);
        push("rst_stall", 0); push("rst_underflow", 0);
        #1;
        popCheck(32'(issue_ready)); popCheck(32'(drained)); popCheck(32'(busy_mask));
        popCheck(32'(stall_cycles)); popCheck(32'(wb_underflow));

        // 1: RAW hazard on r3, cleared by same-cycle WB forwarding
        issueWrite(3'd3);
        push("t1_write_ready", 1);
        #1 popCheck(32'(issue_ready));
        nextCycle();
        issueRead(3'd3);
        push("t1_raw_stall", 0); push("t1_busy_r3", 32'h08);
        #1 popCheck(32'(issue_ready)); popCheck(32'(busy_mask));
        nextCycle();
        WriteEnable_WB  = 1'b1;
        WriteRegAddr_WB = 3'd3;
        push("t1_bypass_ready", 1);
        #1 popCheck(32'(issue_ready));
        nextCycle();
        idle();
        push("t1_busy_clear", 0);
        nextCycle();
        popCheck(32'(busy_mask));

        // 2: counter full on r5 blocks a 4th write until one retires
        for (int k = 0; k < 3; k++) begin
            issueWrite(3'd5);
            push("t2_write_ready", 1);
            #1 popCheck(32'(issue_ready));
            nextCycle();
        end
        issueWrite(3'd5);
        push("t2_full_stall", 0);
        #1 popCheck(32'(issue_ready));
        nextCycle();
        WriteEnable_WB  = 1'b1;
        WriteRegAddr_WB = 3'd5;
        push("t2_no_dest_bypass", 0);
        #1 popCheck(32'(issue_ready));
        nextCycle();
        WriteEnable_WB = 1'b0;
        push("t2_accept_after_dec", 1);
        #1 popCheck(32'(issue_ready));
        nextCycle();
        idle();
        push("t2_busy_r5", 32'h20);
        #1 popCheck(32'(busy_mask));
        for (int k = 0; k < 3; k++) begin
            wbOnly(3'd5);
            nextCycle();
        end
        idle();
        push("t2_busy_clear", 0); push("t2_no_underflow", 0);
        #1 popCheck(32'(busy_mask)); popCheck(32'(wb_underflow));

        // 3: same-cycle issue and WB of r2 leaves pend[2] at 1
        issueWrite(3'd2);
        nextCycle();
        issueWrite(3'd2);
        WriteEnable_WB  = 1'b1;
        WriteRegAddr_WB = 3'd2;
        push("t3_ready", 1);
        #1 popCheck(32'(issue_ready));
        nextCycle();
        idle();
        push("t3_busy_r2", 32'h04);
        #1 popCheck(32'(busy_mask));
        wbOnly(3'd2);
        nextCycle();
        idle();
        push("t3_busy_clear", 0); push("t3_no_underflow", 0);
        #1 popCheck(32'(busy_mask)); popCheck(32'(wb_underflow));

        // 4: WB to an idle register sets the sticky underflow flag
        wbOnly(3'd6);
        nextCycle();
        idle();
        push("t4_underflow", 1); push("t4_busy", 0);
        #1 popCheck(32'(wb_underflow)); popCheck(32'(busy_mask));
        repeat (5) nextCycle();
        push("t4_underflow_sticky", 1);
        popCheck(32'(wb_underflow));

        // 5: drain with two writes pending on r1
        for (int k = 0; k < 2; k++) begin
            issueWrite(3'd1);
            nextCycle();
        end
        idle();
        drain_req = 1'b1;
        push("t5_ready_same_cycle", 1);
        #1 popCheck(32'(issue_ready));
        nextCycle();
        push("t5_drain_blocks", 0); push("t5_not_drained", 0);
        popCheck(32'(issue_ready)); popCheck(32'(drained));
        wbOnly(3'd1);
        nextCycle();
        push("t5_one_left", 0);
        popCheck(32'(drained));
        nextCycle();
        idle();
        push("t5_drained", 1); push("t5_drained_blocks", 0);
        #1 popCheck(32'(drained)); popCheck(32'(issue_ready));
        drain_req = 1'b0;
        nextCycle();
        push("t5_release_drained", 0); push("t5_release_ready", 1);
        popCheck(32'(drained)); popCheck(32'(issue_ready));

        // 5b: empty drain reaches DRAINED two cycles after the request
        drain_req = 1'b1;
        nextCycle();
        push("t5b_drained_cyc1", 0);
        popCheck(32'(drained));
        nextCycle();
        push("t5b_drained_cyc2", 1);
        popCheck(32'(drained));
        drain_req = 1'b0;
        nextCycle();
        push("t5b_release", 0); push("t5b_stall_count", 3);
        popCheck(32'(drained)); popCheck(32'(stall_cycles));

        // 6: long stall saturates the counter, then reset clears everything
        issueWrite(3'd4);
        nextCycle();
        issueRead(3'd4);
        repeat (300) nextCycle();
        push("t6_stall_sat", 255); push("t6_still_stalled", 0);
        popCheck(32'(stall_cycles)); popCheck(32'(issue_ready));
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        idle();
        push("t6_rst_ready", 1); push("t6_rst_drained", 0); push("t6_rst_busy", 0);
        push("t6_rst_stall", 0); push("t6_rst_underflow", 0);
        #1;
        popCheck(32'(issue_ready)); popCheck(32'(drained)); popCheck(32'(busy_mask));
        popCheck(32'(stall_cycles)); popCheck(32'(wb_underflow));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
